// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target: byte width, default idle byte and
// the target FSM state encoding.
package spi_pkg;

  localparam int unsigned SPI_BYTE_W = 8;
  localparam int unsigned SPI_CNT_W  = $clog2(SPI_BYTE_W);

  // Shifted out on miso whenever no TX byte is queued at a byte boundary.
  localparam logic [SPI_BYTE_W-1:0] SPI_IDLE_BYTE = 8'hFF;

  typedef enum logic [0:0] {
    SPI_T_IDLE  = 1'b0,
    SPI_T_SHIFT = 1'b1
  } spi_t_state_e;

endpackage

// File: rtl/spi_target_if.sv
// Pin and byte-bus bundle of the SPI target.
//   SPI pins : sclk, cs_n, mosi (to target), miso, miso_oe (from target)
//   Byte bus : bus_in, cmd_write, cmd_read (to target);
//              bus_out, busy_write, data_avail, overrun, underrun (from target)
// The slave modport is the target's view, the master modport the view of
// whatever drives the pins and the byte bus.
interface spi_target_if;
  import spi_pkg::*;

  logic                  sclk;
  logic                  cs_n;
  logic                  mosi;
  logic                  miso;
  logic                  miso_oe;
  logic [SPI_BYTE_W-1:0] bus_in;
  logic [SPI_BYTE_W-1:0] bus_out;
  logic                  cmd_write;
  logic                  cmd_read;
  logic                  busy_write;
  logic                  data_avail;
  logic                  overrun;
  logic                  underrun;

  modport master (
    output sclk, cs_n, mosi, bus_in, cmd_write, cmd_read,
    input  miso, miso_oe, bus_out, busy_write, data_avail, overrun, underrun
  );

  modport slave (
    input  sclk, cs_n, mosi, bus_in, cmd_write, cmd_read,
    output miso, miso_oe, bus_out, busy_write, data_avail, overrun, underrun
  );

endinterface

// File: rtl/spi_sync.sv
// Input synchronizer with edge detection.
//   clk, reset : system clock, synchronous active-high reset
//   d_i        : asynchronous input
//   s_o        : synchronized level (SYNC_STAGES flops deep)
//   rise_o     : one-cycle pulse on a 0->1 change of s_o
//   fall_o     : one-cycle pulse on a 1->0 change of s_o
// Edges are suppressed until the chain has been refilled after reset, so a
// pin that is already at the non-reset level does not look like an edge.
module spi_sync #(
  parameter int unsigned SYNC_STAGES = 2,  // 2..3
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   prev_q;
  logic [SYNC_STAGES:0]   prime_q;
  logic                   primed;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q  <= RESET_VAL;
      prime_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], d_i};
      prev_q  <= chain_q[SYNC_STAGES-1];
      prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign primed = prime_q[SYNC_STAGES];
  assign s_o    = chain_q[SYNC_STAGES-1];
  assign rise_o = primed &  s_o & ~prev_q;
  assign fall_o = primed & ~s_o &  prev_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target. Oversamples sclk/cs_n/mosi on clk, shifts bytes
// MSB-first full-duplex, and exposes a single-byte buffered byte bus.
//   clk, reset : system clock, synchronous active-high reset
//   bus_io     : SPI pins plus cmd_write/cmd_read handshake and status flags
// TX bytes are loaded into the shifter at select and at every byte boundary
// (sclk fall after a completed byte); an empty buffer sends IDLE_BYTE and
// raises underrun. A received byte overwrites an unread one and raises overrun.
module spi_target
  import spi_pkg::*;
#(
  parameter int unsigned           SYNC_STAGES = 2,  // 2..3
  parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE   = SPI_IDLE_BYTE
) (
  input logic         clk,
  input logic         reset,
  spi_target_if.slave bus_io
);

  localparam logic [SPI_CNT_W-1:0] LastBit = SPI_CNT_W'(SPI_BYTE_W - 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_n_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk    (clk),
    .reset  (reset),
    .d_i    (bus_io.sclk),
    .s_o    (sclk_s),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
    .clk    (clk),
    .reset  (reset),
    .d_i    (bus_io.cs_n),
    .s_o    (cs_n_s),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk    (clk),
    .reset  (reset),
    .d_i    (bus_io.mosi),
    .s_o    (mosi_s),
    .rise_o (mosi_rise),
    .fall_o (mosi_fall)
  );

  spi_t_state_e          state_q, state_d;
  logic [SPI_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [SPI_BYTE_W-1:0] rx_shift_q, rx_shift_d;
  logic [SPI_BYTE_W-1:0] tx_shift_q, tx_shift_d;
  logic [SPI_BYTE_W-1:0] tx_buf_q, tx_buf_d;
  logic                  busy_write_q, busy_write_d;
  logic [SPI_BYTE_W-1:0] rx_buf_q, rx_buf_d;
  logic                  data_avail_q, data_avail_d;
  logic                  overrun_q, overrun_d;
  logic                  underrun_q, underrun_d;
  logic [SPI_BYTE_W-1:0] bus_out_q, bus_out_d;

  logic                  tx_load;
  logic                  rx_done;
  logic [SPI_BYTE_W-1:0] rx_byte;
  logic                  write_acc;
  logic                  read_acc;

  // Shift FSM: select/deselect, bit counting and the two shifters.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    tx_load    = 1'b0;
    rx_done    = 1'b0;
    rx_byte    = {rx_shift_q[SPI_BYTE_W-2:0], mosi_s};

    case (state_q)
      SPI_T_IDLE: begin
        if (cs_fall) begin
          state_d   = SPI_T_SHIFT;
          bit_cnt_d = '0;
          tx_load   = 1'b1;
        end
      end
      SPI_T_SHIFT: begin
        if (cs_rise) begin
          // Deselect wins over any coincident sclk edge; partial bytes vanish.
          state_d    = SPI_T_IDLE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          tx_shift_d = IDLE_BYTE;
        end else begin
          if (sclk_rise) begin
            rx_shift_d = rx_byte;
            bit_cnt_d  = bit_cnt_q + 1'b1;
            rx_done    = (bit_cnt_q == LastBit);
          end
          if (sclk_fall) begin
            if (bit_cnt_q == '0) begin
              tx_load = 1'b1;
            end else begin
              tx_shift_d = {tx_shift_q[SPI_BYTE_W-2:0], 1'b0};
            end
          end
        end
      end
      default: state_d = SPI_T_IDLE;
    endcase

    // The load sees the buffer as it was before any same-cycle write.
    if (tx_load) begin
      tx_shift_d = busy_write_q ? tx_buf_q : IDLE_BYTE;
    end
  end

  // Byte-bus buffers and sticky flags.
  always_comb begin
    write_acc    = bus_io.cmd_write & ~busy_write_q;
    read_acc     = bus_io.cmd_read & data_avail_q;

    tx_buf_d     = write_acc ? bus_io.bus_in : tx_buf_q;
    busy_write_d = busy_write_q;
    if (tx_load)   busy_write_d = 1'b0;
    if (write_acc) busy_write_d = 1'b1;

    underrun_d = underrun_q;
    if (read_acc)               underrun_d = 1'b0;
    if (tx_load & ~busy_write_q) underrun_d = 1'b1;

    rx_buf_d     = rx_done ? rx_byte : rx_buf_q;
    data_avail_d = data_avail_q;
    if (read_acc) data_avail_d = 1'b0;
    if (rx_done)  data_avail_d = 1'b1;

    // A read in the completion cycle consumes the old byte, so no loss.
    overrun_d = overrun_q;
    if (read_acc) begin
      overrun_d = 1'b0;
    end else if (rx_done & data_avail_q) begin
      overrun_d = 1'b1;
    end

    bus_out_d = read_acc ? rx_buf_q : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SPI_T_IDLE;
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      tx_shift_q   <= IDLE_BYTE;
      tx_buf_q     <= '0;
      busy_write_q <= 1'b0;
      rx_buf_q     <= '0;
      data_avail_q <= 1'b0;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
      bus_out_q    <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      tx_buf_q     <= tx_buf_d;
      busy_write_q <= busy_write_d;
      rx_buf_q     <= rx_buf_d;
      data_avail_q <= data_avail_d;
      overrun_q    <= overrun_d;
      underrun_q   <= underrun_d;
      bus_out_q    <= bus_out_d;
    end
  end

  assign bus_io.miso       = (state_q == SPI_T_SHIFT) ? tx_shift_q[SPI_BYTE_W-1] : 1'b1;
  assign bus_io.miso_oe    = ~cs_n_s;
  assign bus_io.bus_out    = bus_out_q;
  assign bus_io.busy_write = busy_write_q;
  assign bus_io.data_avail = data_avail_q;
  assign bus_io.overrun    = overrun_q;
  assign bus_io.underrun   = underrun_q;

  // Only edges of sclk and only the level of mosi are needed.
  logic unused_sync;
  assign unused_sync = ^{sclk_s, mosi_rise, mosi_fall, rx_shift_q[SPI_BYTE_W-1]};

endmodule

// File: tb/tb_spi_target.sv
module tb_spi_target;

  localparam int unsigned SyncStages = 2;
  localparam logic [7:0]  IdleByte   = 8'hFF;
  localparam int          Half       = 6;  // sclk half period in clk cycles

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_target_if bus ();

  spi_target #(
    .SYNC_STAGES (SyncStages),
    .IDLE_BYTE   (IdleByte)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard queues: expected miso bits and expected bus_out bytes.
  logic       miso_q[$];
  logic [7:0] rd_q[$];

  // Reference model of the buffers and flags.
  logic       m_full;
  logic [7:0] m_buf;
  logic [7:0] m_rxbuf;
  logic       m_avail, m_over, m_under;

  // Optional writes issued in the middle of the first byte of a transfer.
  int         mw_n = 0;
  logic [7:0] mw_v[2];
  logic [7:0] t0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, wanted %02h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void m_reset();
    m_full  = 1'b0;
    m_buf   = 8'h00;
    m_rxbuf = 8'h00;
    m_avail = 1'b0;
    m_over  = 1'b0;
    m_under = 1'b0;
  endfunction

  // Byte handed to the shifter at select or at a byte boundary.
  function automatic logic [7:0] m_load();
    logic [7:0] r;
    if (m_full) begin
      r      = m_buf;
      m_full = 1'b0;
    end else begin
      r       = IdleByte;
      m_under = 1'b1;
    end
    return r;
  endfunction

  function automatic void m_rx(input logic [7:0] b);
    if (m_avail) m_over = 1'b1;
    m_rxbuf = b;
    m_avail = 1'b1;
  endfunction

  task automatic chk_flags(input string tag);
    check({tag, ".busy"},     {7'b0, bus.busy_write}, {7'b0, m_full});
    check({tag, ".avail"},    {7'b0, bus.data_avail}, {7'b0, m_avail});
    check({tag, ".overrun"},  {7'b0, bus.overrun},    {7'b0, m_over});
    check({tag, ".underrun"}, {7'b0, bus.underrun},   {7'b0, m_under});
    check({tag, ".miso"},     {7'b0, bus.miso},       8'h01);
    check({tag, ".miso_oe"},  {7'b0, bus.miso_oe},    8'h00);
  endtask

  task automatic do_write(input logic [7:0] v);
    check("busy_before_write", {7'b0, bus.busy_write}, {7'b0, m_full});
    bus.bus_in    = v;
    bus.cmd_write = 1'b1;
    if (!m_full) begin
      m_full = 1'b1;
      m_buf  = v;
    end
    cyc(1);
    bus.cmd_write = 1'b0;
  endtask

  task automatic do_read();
    bus.cmd_read = 1'b1;
    if (m_avail) begin
      rd_q.push_back(m_rxbuf);
      m_avail = 1'b0;
      m_over  = 1'b0;
      m_under = 1'b0;
    end else begin
      rd_q.push_back(8'h00);
    end
    cyc(1);
    bus.cmd_read = 1'b0;
    cyc(2);
  endtask

  // Full transfer: nbytes whole bytes then an optional partial byte of tail bits.
  task automatic xfer(input int nbytes, input int tail, input logic [7:0] d0,
                      input logic [7:0] d1);
    logic [7:0] t;
    logic [7:0] m;
    int         nb;
    t = m_load();
    bus.cs_n = 1'b0;
    cyc(8);
    check("miso_oe_selected", {7'b0, bus.miso_oe}, 8'h01);
    for (int b = 0; b < nbytes + ((tail > 0) ? 1 : 0); b++) begin
      nb = (b < nbytes) ? 8 : tail;
      m  = (b == 0) ? d0 : (b == 1) ? d1 : 8'($urandom());
      for (int i = 0; i < nb; i++) miso_q.push_back(t[7-i]);
      for (int i = 0; i < nb; i++) begin
        bus.mosi = m[7-i];
        cyc(Half);
        bus.sclk = 1'b1;
        cyc(Half);
        bus.sclk = 1'b0;
        if (b == 0 && i == 3) begin
          for (int k = 0; k < mw_n; k++) do_write(mw_v[k]);
          mw_n = 0;
        end
      end
      if (nb == 8) begin
        m_rx(m);
        t = m_load();
      end
    end
    mw_n = 0;
    cyc(Half);
    bus.cs_n = 1'b1;
    cyc(8);
  endtask

  // Monitor: miso is sampled by the initiator on each sclk rise.
  always @(posedge bus.sclk) begin
    if (!bus.cs_n) begin
      if (miso_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL miso_unexpected_bit: got %0b, wanted no sclk edge", bus.miso);
      end else begin
        check("miso", {7'b0, bus.miso}, {7'b0, miso_q.pop_front()});
      end
    end
  end

  // Monitor: bus_out is presented the cycle after cmd_read, then returns to 0.
  logic rd_now;
  logic rd_prev = 1'b0;
  always begin
    @(posedge clk);
    rd_now = bus.cmd_read;
    #2;
    if (rd_now === 1'b1) begin
      if (rd_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL bus_out_unexpected: got %02h, wanted no read", bus.bus_out);
      end else begin
        check("bus_out", bus.bus_out, rd_q.pop_front());
      end
    end else if (rd_prev) begin
      check("bus_out_clear", bus.bus_out, 8'h00);
    end
    rd_prev = (rd_now === 1'b1);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, wanted $finish");
    $fatal(1);
  end

  initial begin
    int nb;
    int tl;
    bus.sclk      = 1'b0;
    bus.cs_n      = 1'b1;
    bus.mosi      = 1'b0;
    bus.bus_in    = 8'h00;
    bus.cmd_write = 1'b0;
    bus.cmd_read  = 1'b0;
    reset         = 1'b1;
    m_reset();
    cyc(4);
    chk_flags("reset");
    check("reset.bus_out", bus.bus_out, 8'h00);
    reset = 1'b0;
    cyc(6);

    // Queued A5 out, 3C in.
    do_write(8'hA5);
    check("queued.busy", {7'b0, bus.busy_write}, 8'h01);
    xfer(1, 0, 8'h3C, 8'h00);
    chk_flags("a5_3c");
    do_read();
    chk_flags("a5_3c_read");

    // Nothing queued: two idle bytes and underrun.
    xfer(2, 0, 8'h5A, 8'hC6);
    chk_flags("underrun");
    do_read();

    // Two bytes without reading: overrun, newest byte kept.
    xfer(2, 0, 8'h11, 8'h22);
    chk_flags("overrun");
    do_read();
    chk_flags("overrun_read");

    // Mid-byte writes: the second is ignored while the buffer is full.
    mw_n    = 2;
    mw_v[0] = 8'h81;
    mw_v[1] = 8'h7E;
    xfer(2, 0, 8'h0F, 8'hF0);
    chk_flags("midwrite");
    do_read();

    // Aborted byte after 5 bits, then a clean C3.
    xfer(0, 5, 8'hAA, 8'h00);
    chk_flags("abort");
    xfer(1, 0, 8'hC3, 8'h00);
    chk_flags("after_abort");
    do_read();

    // Reset in the middle of a byte.
    do_write(8'h5A);
    t0 = m_load();
    bus.cs_n = 1'b0;
    cyc(8);
    for (int i = 0; i < 3; i++) miso_q.push_back(t0[7-i]);
    for (int i = 0; i < 3; i++) begin
      bus.mosi = 1'($urandom());
      cyc(Half);
      bus.sclk = 1'b1;
      cyc(Half);
      bus.sclk = 1'b0;
    end
    cyc(2);
    reset = 1'b1;
    cyc(2);
    m_reset();
    chk_flags("midreset");
    check("midreset.bus_out", bus.bus_out, 8'h00);
    bus.cs_n = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(8);
    do_write(8'h69);
    xfer(1, 0, 8'h96, 8'h00);
    chk_flags("post_reset");
    do_read();

    // Randomized traffic.
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 1) == 1) do_write(8'($urandom()));
      if ($urandom_range(0, 3) == 0) do_write(8'($urandom()));
      nb = int'($urandom_range(0, 3));
      tl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      if (nb == 0 && tl == 0) nb = 1;
      if ($urandom_range(0, 3) == 0) begin
        mw_n    = 1;
        mw_v[0] = 8'($urandom());
      end
      xfer(nb, tl, 8'($urandom()), 8'($urandom()));
      chk_flags("random");
      if ($urandom_range(0, 2) != 0) do_read();
      if ($urandom_range(0, 3) == 0) do_read();
    end

    cyc(4);
    check("miso_queue_drained", 8'(miso_q.size()), 8'h00);
    check("read_queue_drained", 8'(rd_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
